// File: rtl/countdown_ctrl.sv
// Down-counter controller with pause, abort and optional auto-reload.
// It also keeps a saturating count of the countdowns completed since the last start.
module countdown_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic             done,
  output logic [PW-1:0]    periods
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_reload, w_reload_next;
  logic [PW-1:0]    r_periods, w_periods_next;
  logic [PW-1:0]    w_periods_inc;

  assign w_periods_inc = (r_periods == {PW{1'b1}}) ? r_periods : r_periods + 1'b1;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_reload  <= '0;
      r_periods <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_reload  <= w_reload_next;
      r_periods <= w_periods_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_reload_next  = r_reload;
    w_periods_next = r_periods;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_cnt_next     = load_val;
          w_reload_next  = load_val;
          w_periods_next = '0;
          w_state_next   = StRun;
        end
      end
      StRun: begin
        // Abort outranks pause, which outranks completion.
        if (abort) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (pause) begin
          w_state_next = StPaused;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_state_next = StDone;
        end
      end
      StPaused: begin
        if (abort) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (!pause) begin
          w_state_next = StRun;
        end
      end
      StDone: begin
        // The pulse is already visible, so the period counts even if aborted.
        w_periods_next = w_periods_inc;
        if (abort) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (auto_reload) begin
          w_state_next = StRun;
          w_cnt_next   = r_reload;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign ready   = (r_state == StIdle);
  assign busy    = (r_state != StIdle);
  assign done    = (r_state == StDone);
  assign cnt     = r_cnt;
  assign periods = r_periods;

endmodule
